fp_divider: RTL
===============

Name: fp_divider

Overview:
- Multi-cycle IEEE-754 single-precision divider for the RISC5 FPU, alongside the FP adder and multiplier.
- Uses the same run/stall handshake: the core raises run, the block stalls the pipeline until the quotient z is valid.
- Iterative restoring mantissa division, one quotient bit per clock.
- Result is truncated (no rounding), denormals are flushed to zero, and there is no NaN support. This matches the adder's numeric conventions.

Parameters:
- EXP_W, 8, exponent field width. Only the default is supported and verified.
- FRAC_W, 23, fraction field width. Only the default is supported and verified.
- BIAS, 127, exponent bias.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-low reset.
- run  in  1  FDIV instruction in execute stage; x and y are held stable while stall=1.
- x  in  32  dividend.
- y  in  32  divisor.
- stall  out  1  combinational: run & (state != DONE).
- z  out  32  quotient; valid in the DONE cycle and held until the next start.

Behaviour:
- Reset (rst=0, asynchronous):
  - state=IDLE, cnt=0, remainder/quotient/exponent/sign registers cleared, z=0.
  - stall follows run & (state != DONE), so it is 1 if run=1 during reset.
- States are IDLE, DIV and DONE.
- IDLE:
  - If run=1, load R={1'b0,1,x[22:0]}, D={1,y[22:0]}, Q=0, cnt=0, and latch the following; then go to DIV.
    - s=x[31]^y[31].
    - e=({2'b0,x[30:23]}-{2'b0,y[30:23]}+BIAS-1), a 10-bit signed value.
    - Flags: xz=(x[30:23]==0), yz=(y[30:23]==0), both latched.
  - Otherwise stay in IDLE.
- DIV:
  - Each cycle: d=R-{1'b0,D}.
    - If d>=0: Q={Q[23:0],1}, R=d<<1.
    - Else: Q={Q[23:0],0}, R=R<<1.
  - cnt increments; after the iteration with cnt=24 (25 iterations in total), go to DONE.
  - If run falls during DIV, abort to IDLE on the next edge. Result registers are undefined; z need not be valid.
- DONE:
  - Lasts exactly one cycle, then unconditionally goes to IDLE.
  - If run is still 1 in that IDLE cycle, a new division starts (back-to-back FDIV).
- Timing:
  - Start cycle (IDLE, run=1) is cycle 0 with stall=1; DIV occupies cycles 1..25 with stall=1; DONE is cycle 26 with stall=0.
  - Total: 26 stall cycles, result consumed at cycle 26.
- Normalisation (combinational from registers):
  - Q[24]=1 gives mant=Q[23:1] and ef=e+1.
  - Q[24]=0 gives mant=Q[22:0] and ef=e.
- Result priority:
  1. xz: z=32'h0 (this includes 0/0).
  2. yz: z={s,8'hFF,23'h0} (divide by zero gives signed infinity).
  3. ef<=0 (ef[9] set or ef==0): z=32'h0 (underflow).
  4. ef>=255: z={s,8'hFF,23'h0} (overflow).
  5. Otherwise z={s,ef[7:0],mant}.
- z is registered on entry to DONE and held through IDLE until the next start.
- The divisor mantissa is always nonzero, because the divisor is 1.xxx when yz=0, so no special iteration cases arise.
- x/y changing while stall=1 is a protocol violation; the behaviour is unspecified.

Decomposition:
- Shared package fp_pkg holds:
  - EXP_W, FRAC_W and BIAS.
  - The ITER=FRAC_W+2 derivation.
  - The state encoding (IDLE/DIV/DONE, 2 bits).
  - The INF_MAG=31'h7F800000 constant.
  - The exponent arithmetic width (EXP_W+2).
- One sub-module, fp_div_step: purely combinational.
  - In: R and D. Out: next R and the quotient bit.
  - Reused if the team later unrolls to 2 bits per cycle.
- FSM, counter, exponent path and packing stay in fp_divider.

Test Plan:
- x=40C00000 (6.0), y=40000000 (2.0), run held high: stall=1 for exactly 26 cycles, then z=40400000.
- x=3F800000 (1.0), y=40400000 (3.0): z=3EAAAAAA (truncated). x=BF800000, y=40800000: z=BE800000.
- Specials:
  - x=00000000, y=40000000 gives z=00000000.
  - x=3F800000, y=00000000 gives 7F800000.
  - x=BF800000, y=80000000 gives 7F800000.
  - x=00400000 (denormal), y=3F800000 gives 00000000.
- Range limits: x=7F000000, y=00800000 gives z=7F800000 (overflow); x=00800000, y=7F000000 gives z=00000000 (underflow).
- Back-to-back: run held high across two FDIVs (6/2, then 1/3). Expect:
  - stall=0 only in cycle 26;
  - the second operation starts in cycle 27 and completes in cycle 53;
  - z=40400000, then 3EAAAAAA.
- Reset and abort:
  - rst=0 at cycle 10 of an operation: z=0 and state=IDLE immediately.
  - After release with run=1: a full 26-cycle stall, then the correct quotient.
  - run dropped at cycle 5: IDLE next cycle, stall=0.

Source files
------------

// File: rtl/fp_pkg.sv
// Shared constants and types for the FPU divider: field widths, iteration
// count, exponent arithmetic width and the FSM state encoding.
package fp_pkg;

  localparam int EXP_W  = 8;
  localparam int FRAC_W = 23;
  localparam int BIAS   = 127;

  localparam int WORD_W   = 1 + EXP_W + FRAC_W;  // 32-bit IEEE single
  localparam int SIGN_BIT = WORD_W - 1;
  localparam int MANT_W   = FRAC_W + 1;          // divisor 1.fff
  localparam int REM_W    = MANT_W + 1;          // remainder never reaches 2*D
  localparam int ITER     = FRAC_W + 2;          // quotient bits produced
  localparam int CNT_W    = $clog2(ITER);
  localparam int EXP_AW   = EXP_W + 2;           // signed exponent with headroom

  localparam logic [CNT_W-1:0]    LAST_CNT = CNT_W'(ITER - 1);
  localparam logic [EXP_AW-1:0]   EXP_OFS  = EXP_AW'(BIAS - 1);
  localparam logic [EXP_AW-1:0]   EXP_MAX  = EXP_AW'((1 << EXP_W) - 1);
  localparam logic [WORD_W-2:0]   INF_MAG  = 31'h7F800000;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    DIV  = 2'd1,
    DONE = 2'd2
  } state_e;

endpackage

// File: rtl/fp_div_step.sv
// One restoring-division step: trial-subtract the divisor, emit the quotient
// bit and the shifted partial remainder for the next step.
module fp_div_step
  import fp_pkg::*;
(
  input  logic [REM_W-1:0]  rem_i,
  input  logic [MANT_W-1:0] dsr_i,
  output logic [REM_W-1:0]  rem_o,
  output logic              q_o
);

  // One extra bit so a negative trial result is seen as a borrow.
  logic [REM_W:0] diff;

  // Trial subtraction and restore-or-keep selection.
  always_comb begin
    diff  = {1'b0, rem_i} - {2'b00, dsr_i};
    q_o   = ~diff[REM_W];
    rem_o = q_o ? (diff[REM_W-1:0] << 1) : (rem_i << 1);
  end

endmodule

// File: rtl/fp_divider.sv
// Multi-cycle single-precision divider with run/stall handshake. One quotient
// bit per clock, truncating, denormals flushed to zero, no NaN handling.
module fp_divider
  import fp_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              run,
  input  logic [WORD_W-1:0] x,
  input  logic [WORD_W-1:0] y,
  output logic              stall,
  output logic [WORD_W-1:0] z
);

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q,   cnt_d;
  logic [REM_W-1:0]   rem_q,   rem_d;
  logic [MANT_W-1:0]  dsr_q,   dsr_d;
  // Only the low ITER-1 quotient bits are stored: the leading bit is only
  // needed after the final shift, where it comes straight from the step.
  logic [ITER-2:0]    quo_q,   quo_d;
  logic [EXP_AW-1:0]  exp_q,   exp_d;
  logic               sign_q,  sign_d;
  logic               xz_q,    xz_d;
  logic               yz_q,    yz_d;
  logic [WORD_W-1:0]  z_q,     z_d;

  logic [REM_W-1:0]   rem_step;
  logic               q_bit;
  logic [ITER-1:0]    quo_step;
  logic [EXP_AW-1:0]  exp_fin;
  logic [FRAC_W-1:0]  mant;
  logic [WORD_W-1:0]  packed_z;

  fp_div_step u_step (
    .rem_i (rem_q),
    .dsr_i (dsr_q),
    .rem_o (rem_step),
    .q_o   (q_bit)
  );

  assign quo_step = {quo_q, q_bit};
  assign stall    = run & (state_q != DONE);
  assign z        = z_q;

  // Normalise the quotient that the current step completes and pack the result.
  always_comb begin
    exp_fin = quo_step[ITER-1] ? exp_q + 1'b1 : exp_q;
    mant    = quo_step[ITER-1] ? quo_step[ITER-2:1] : quo_step[ITER-3:0];
    if (xz_q) begin
      packed_z = '0;
    end else if (yz_q) begin
      packed_z = {sign_q, INF_MAG};
    end else if (exp_fin[EXP_AW-1] || (exp_fin == '0)) begin
      packed_z = '0;
    end else if (exp_fin >= EXP_MAX) begin
      packed_z = {sign_q, INF_MAG};
    end else begin
      packed_z = {sign_q, exp_fin[EXP_W-1:0], mant};
    end
  end

  // Next-state logic for the FSM and the datapath registers.
  always_comb begin
    // NOTE: every _d starts from its _q so no path through the case leaves a
    // variable unassigned, which would otherwise infer a latch.
    state_d = state_q;
    cnt_d   = cnt_q;
    rem_d   = rem_q;
    dsr_d   = dsr_q;
    quo_d   = quo_q;
    exp_d   = exp_q;
    sign_d  = sign_q;
    xz_d    = xz_q;
    yz_d    = yz_q;
    z_d     = z_q;
    unique case (state_q)
      IDLE: begin
        if (run) begin
          state_d = DIV;
          cnt_d   = '0;
          rem_d   = {1'b0, 1'b1, x[FRAC_W-1:0]};
          dsr_d   = {1'b1, y[FRAC_W-1:0]};
          quo_d   = '0;
          sign_d  = x[SIGN_BIT] ^ y[SIGN_BIT];
          exp_d   = {2'b00, x[SIGN_BIT-1:FRAC_W]} - {2'b00, y[SIGN_BIT-1:FRAC_W]}
                    + EXP_OFS;
          xz_d    = (x[SIGN_BIT-1:FRAC_W] == '0);
          yz_d    = (y[SIGN_BIT-1:FRAC_W] == '0);
        end
      end
      DIV: begin
        if (!run) begin
          state_d = IDLE;
        end else begin
          rem_d = rem_step;
          quo_d = quo_step[ITER-2:0];
          cnt_d = cnt_q + 1'b1;
          if (cnt_q == LAST_CNT) begin
            state_d = DONE;
            z_d     = packed_z;
          end
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // State and datapath registers, all cleared by the asynchronous reset.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      rem_q   <= '0;
      dsr_q   <= '0;
      quo_q   <= '0;
      exp_q   <= '0;
      sign_q  <= 1'b0;
      xz_q    <= 1'b0;
      yz_q    <= 1'b0;
      z_q     <= '0;
    end else begin
      // NOTE: non-blocking assignments so every register samples the values
      // from before this edge, independent of statement order.
      state_q <= state_d;
      cnt_q   <= cnt_d;
      rem_q   <= rem_d;
      dsr_q   <= dsr_d;
      quo_q   <= quo_d;
      exp_q   <= exp_d;
      sign_q  <= sign_d;
      xz_q    <= xz_d;
      yz_q    <= yz_d;
      z_q     <= z_d;
    end
  end

endmodule
